// File: rtl/alu_share_if.sv
// ============================================================================
// Module   : alu_share_if
// Brief    : Requester, response, ALU-side and flag signals of the ALU sharing arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_share_if #(
    parameter int DW  = 16,
    parameter int OPW = 4,
    parameter int SHW = 4
);
    logic           req0_vld;
    logic           req0_rdy;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_src0;
    logic [DW-1:0]  req0_src1;
    logic [SHW-1:0] req0_shamt;

    logic           req1_vld;
    logic           req1_rdy;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_src0;
    logic [DW-1:0]  req1_src1;
    logic [SHW-1:0] req1_shamt;

    logic           rsp_vld;
    logic           rsp_rdy;
    logic           rsp_id;
    logic [DW-1:0]  rsp_dst;
    logic           rsp_ov;
    logic           rsp_zr;
    logic           rsp_neg;

    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_src0;
    logic [DW-1:0]  alu_src1;
    logic [SHW-1:0] alu_shamt;
    logic [DW-1:0]  alu_dst;
    logic           alu_ov;
    logic           alu_zr;
    logic           alu_neg;
    logic           alu_chg_v;
    logic           alu_chg_z;
    logic           alu_chg_n;

    logic           flag_v;
    logic           flag_z;
    logic           flag_n;

    // Arbiter side
    modport slave (
        input  req0_vld, req0_op, req0_src0, req0_src1, req0_shamt,
        input  req1_vld, req1_op, req1_src0, req1_src1, req1_shamt,
        input  rsp_rdy,
        input  alu_dst, alu_ov, alu_zr, alu_neg, alu_chg_v, alu_chg_z, alu_chg_n,
        output req0_rdy, req1_rdy,
        output rsp_vld, rsp_id, rsp_dst, rsp_ov, rsp_zr, rsp_neg,
        output alu_op, alu_src0, alu_src1, alu_shamt,
        output flag_v, flag_z, flag_n
    );

    // Requester / consumer / ALU side
    modport master (
        output req0_vld, req0_op, req0_src0, req0_src1, req0_shamt,
        output req1_vld, req1_op, req1_src0, req1_src1, req1_shamt,
        output rsp_rdy,
        output alu_dst, alu_ov, alu_zr, alu_neg, alu_chg_v, alu_chg_z, alu_chg_n,
        input  req0_rdy, req1_rdy,
        input  rsp_vld, rsp_id, rsp_dst, rsp_ov, rsp_zr, rsp_neg,
        input  alu_op, alu_src0, alu_src1, alu_shamt,
        input  flag_v, flag_z, flag_n
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Shares one ALU between two requesters; round-robin grant, registered
//            result return and V/Z/N flag register. Define ALU_FIXED_PRIO_EN for
//            fixed req0-first priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
    parameter int DW  = 16,
    parameter int OPW = 4,
    parameter int SHW = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_share_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic [OPW-1:0] r_alu_op;
    logic [DW-1:0]  r_alu_src0;
    logic [DW-1:0]  r_alu_src1;
    logic [SHW-1:0] r_alu_shamt;
    logic           r_rsp_vld;
    logic           r_rsp_id;
    logic [DW-1:0]  r_rsp_dst;
    logic           r_rsp_ov;
    logic           r_rsp_zr;
    logic           r_rsp_neg;
    logic           r_flag_v;
    logic           r_flag_z;
    logic           r_flag_n;

    logic           w_can_grant;
    logic           w_any_vld;
    logic           w_sel1;
    logic           w_gnt0;
    logic           w_gnt1;
    logic [OPW-1:0] w_cap_op;
    logic [DW-1:0]  w_cap_src0;
    logic [DW-1:0]  w_cap_src1;
    logic [SHW-1:0] w_cap_shamt;

    // A new operation may be accepted when idle, or when the held result leaves this cycle.
    assign w_can_grant = !rst && ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_rdy));
    assign w_any_vld   = bus.req0_vld || bus.req1_vld;

`ifdef ALU_FIXED_PRIO_EN
    assign w_sel1 = bus.req1_vld && !bus.req0_vld;
`else
    assign w_sel1 = bus.req1_vld && (!bus.req0_vld || !r_last_grant);
`endif

    assign w_gnt1 = w_can_grant && w_any_vld && w_sel1;
    assign w_gnt0 = w_can_grant && w_any_vld && !w_sel1;

    assign w_cap_op    = w_sel1 ? bus.req1_op    : bus.req0_op;
    assign w_cap_src0  = w_sel1 ? bus.req1_src0  : bus.req0_src0;
    assign w_cap_src1  = w_sel1 ? bus.req1_src1  : bus.req0_src1;
    assign w_cap_shamt = w_sel1 ? bus.req1_shamt : bus.req0_shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_alu_op     <= '0;
            r_alu_src0   <= '0;
            r_alu_src1   <= '0;
            r_alu_shamt  <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_dst    <= '0;
            r_rsp_ov     <= 1'b0;
            r_rsp_zr     <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_flag_v     <= 1'b0;
            r_flag_z     <= 1'b0;
            r_flag_n     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_alu_op     <= w_cap_op;
                        r_alu_src0   <= w_cap_src0;
                        r_alu_src1   <= w_cap_src1;
                        r_alu_shamt  <= w_cap_shamt;
                        r_rsp_id     <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_vld <= 1'b1;
                    r_rsp_dst <= bus.alu_dst;
                    r_rsp_ov  <= bus.alu_ov;
                    r_rsp_zr  <= bus.alu_zr;
                    r_rsp_neg <= bus.alu_neg;
                    if (bus.alu_chg_v) r_flag_v <= bus.alu_ov;
                    if (bus.alu_chg_z) r_flag_z <= bus.alu_zr;
                    if (bus.alu_chg_n) r_flag_n <= bus.alu_neg;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        // Back-to-back: capture the next operation as the result retires.
                        if (w_gnt0 || w_gnt1) begin
                            r_alu_op     <= w_cap_op;
                            r_alu_src0   <= w_cap_src0;
                            r_alu_src1   <= w_cap_src1;
                            r_alu_shamt  <= w_cap_shamt;
                            r_rsp_id     <= w_gnt1;
                            r_last_grant <= w_gnt1;
                            r_state      <= S_EXEC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_rdy  = w_gnt0;
    assign bus.req1_rdy  = w_gnt1;
    assign bus.rsp_vld   = r_rsp_vld;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_dst   = r_rsp_dst;
    assign bus.rsp_ov    = r_rsp_ov;
    assign bus.rsp_zr    = r_rsp_zr;
    assign bus.rsp_neg   = r_rsp_neg;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_src0  = r_alu_src0;
    assign bus.alu_src1  = r_alu_src1;
    assign bus.alu_shamt = r_alu_shamt;
    assign bus.flag_v    = r_flag_v;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_n    = r_flag_n;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Self-checking bench for alu_share_arbiter with an ALU stand-in and
//            a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
    } op_t;

    typedef struct packed {
        logic [15:0] dst;
        logic        ov;
        logic        zr;
        logic        neg;
        logic        cv;
        logic        cz;
        logic        cn;
    } res_t;

    typedef struct packed {
        logic id;
        res_t r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_if #(.DW(16), .OPW(4), .SHW(4)) bus ();

    alu_share_arbiter #(.DW(16), .OPW(4), .SHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, others pass src0.
    function automatic res_t alu_ref(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] sh);
        res_t        r;
        logic [15:0] d;
        r = '0;
        d = a;
        case (op)
            4'd0: begin d = a + b; r.ov = (a[15] == b[15]) && (d[15] != a[15]); r.cv = 1'b1; r.cz = 1'b1; r.cn = 1'b1; end
            4'd1: begin d = a - b; r.ov = (a[15] != b[15]) && (d[15] != a[15]); r.cv = 1'b1; r.cz = 1'b1; r.cn = 1'b1; end
            4'd2: begin d = a & b; r.cz = 1'b1; end
            4'd3: begin d = a | b; r.cz = 1'b1; end
            4'd4: begin d = a ^ b; r.cz = 1'b1; end
            4'd5: begin d = a << sh; r.cz = 1'b1; r.cn = 1'b1; end
            default: d = a;
        endcase
        r.dst = d;
        r.zr  = (d == 16'h0000);
        r.neg = d[15];
        return r;
    endfunction

    res_t w_alu;
    always_comb w_alu = alu_ref(bus.alu_op, bus.alu_src0, bus.alu_src1, bus.alu_shamt);
    assign bus.alu_dst   = w_alu.dst;
    assign bus.alu_ov    = w_alu.ov;
    assign bus.alu_zr    = w_alu.zr;
    assign bus.alu_neg   = w_alu.neg;
    assign bus.alu_chg_v = w_alu.cv;
    assign bus.alu_chg_z = w_alu.cz;
    assign bus.alu_chg_n = w_alu.cn;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    logic gseq[$];
    int   gcyc[$];
    logic g0 = 1'b0;
    logic g1 = 1'b0;
    int   m_state = 0;
    logic m_last  = 1'b1;
    logic [2:0] m_flags = 3'b000;
    int   cyc = 0;

    function automatic bit is_idle();
        return (q0.size() == 0) && (q1.size() == 0) && (m_state == 0) && (sb.size() == 0);
    endfunction

    // Requesters: hold vld and payload until the grant edge.
    initial begin
        bus.req0_vld = 1'b0; bus.req0_op = '0; bus.req0_src0 = '0; bus.req0_src1 = '0; bus.req0_shamt = '0;
        bus.req1_vld = 1'b0; bus.req1_op = '0; bus.req1_src0 = '0; bus.req1_src1 = '0; bus.req1_shamt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (g0 && q0.size() > 0) void'(q0.pop_front());
            if (g1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                bus.req0_vld = 1'b1; bus.req0_op = q0[0].op; bus.req0_src0 = q0[0].a;
                bus.req0_src1 = q0[0].b; bus.req0_shamt = q0[0].sh;
            end else begin
                bus.req0_vld = 1'b0;
            end
            if (q1.size() > 0) begin
                bus.req1_vld = 1'b1; bus.req1_op = q1[0].op; bus.req1_src0 = q1[0].a;
                bus.req1_src1 = q1[0].b; bus.req1_shamt = q1[0].sh;
            end else begin
                bus.req1_vld = 1'b0;
            end
        end
    end

    // Transaction model, evaluated just before each active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_state = 0; m_last = 1'b1; m_flags = 3'b000;
                sb.delete();
                g0 = 1'b0; g1 = 1'b0;
            end else begin
                bit   can;
                logic e0, e1;
                exp_t e;
                can = (m_state == 0) || (m_state == 2 && bus.rsp_rdy);
                e0 = 1'b0; e1 = 1'b0;
                if (can && (bus.req0_vld || bus.req1_vld)) begin
`ifdef ALU_FIXED_PRIO_EN
                    e1 = !bus.req0_vld;
`else
                    e1 = bus.req1_vld && (!bus.req0_vld || m_last == 1'b0);
`endif
                    e0 = !e1;
                end
                check("rdy0", {31'd0, bus.req0_rdy}, {31'd0, e0});
                check("rdy1", {31'd0, bus.req1_rdy}, {31'd0, e1});
                if (m_state == 2) begin
                    check("rsp_vld", {31'd0, bus.rsp_vld}, 32'd1);
                    check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0)
                        check("rsp_data",
                              {12'd0, bus.rsp_id, bus.rsp_dst, bus.rsp_ov, bus.rsp_zr, bus.rsp_neg},
                              {12'd0, sb[0].id, sb[0].r.dst, sb[0].r.ov, sb[0].r.zr, sb[0].r.neg});
                end else begin
                    check("rsp_idle", {31'd0, bus.rsp_vld}, 32'd0);
                end
                check("flags", {29'd0, bus.flag_v, bus.flag_z, bus.flag_n}, {29'd0, m_flags});

                e.id = e1;
                e.r  = e1 ? alu_ref(bus.req1_op, bus.req1_src0, bus.req1_src1, bus.req1_shamt)
                          : alu_ref(bus.req0_op, bus.req0_src0, bus.req0_src1, bus.req0_shamt);
                case (m_state)
                    0: if (e0 || e1) begin sb.push_back(e); m_last = e1; m_state = 1; end
                    1: begin
                        if (sb.size() > 0) begin
                            if (sb[$].r.cv) m_flags[2] = sb[$].r.ov;
                            if (sb[$].r.cz) m_flags[1] = sb[$].r.zr;
                            if (sb[$].r.cn) m_flags[0] = sb[$].r.neg;
                        end
                        m_state = 2;
                    end
                    default: if (bus.rsp_rdy) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        if (e0 || e1) begin sb.push_back(e); m_last = e1; m_state = 1; end
                        else m_state = 0;
                    end
                endcase
                g0 = bus.req0_rdy;
                g1 = bus.req1_rdy;
                if (bus.req0_rdy || bus.req1_rdy) begin
                    gseq.push_back(bus.req1_rdy);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!is_idle() && n < budget);
        if (!is_idle()) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rdy0(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req0_rdy && n < budget);
        if (!bus.req0_rdy) check("grant_timeout", 32'd0, 32'd1);
    endtask

    function automatic op_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.sh = 4'd0;
        return o;
    endfunction

    initial begin
        bus.rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        check("rst_flags", {29'd0, bus.flag_v, bus.flag_z, bus.flag_n}, 32'd0);
        check("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        check("rst_alu_src", {bus.alu_src0, bus.alu_src1}, 32'd0);
        check("rst_rsp_dst", {16'd0, bus.rsp_dst}, 32'd0);

        // ADD overflow into the sign bit
        q0.push_back(mk(4'd0, 16'h7FFF, 16'h0001));
        wait_rdy0(20);
        @(negedge clk);
        check("t1_exec_no_vld", {31'd0, bus.rsp_vld}, 32'd0);
        @(negedge clk);
        check("t1_vld_n2", {31'd0, bus.rsp_vld}, 32'd1);
        check("t1_rsp", {12'd0, bus.rsp_id, bus.rsp_dst, bus.rsp_ov, bus.rsp_zr, bus.rsp_neg},
              {12'd0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1});
        wait_idle(50);
        check("t1_flags", {29'd0, bus.flag_v, bus.flag_z, bus.flag_n}, 32'b101);

        // AND to zero touches only Z
        q0.push_back(mk(4'd2, 16'h00F0, 16'h0F00));
        wait_idle(50);
        check("t3_flags", {29'd0, bus.flag_v, bus.flag_z, bus.flag_n}, 32'b111);

        // Reset while the operation is executing
        q0.push_back(mk(4'd0, 16'h0001, 16'h0002));
        wait_rdy0(20);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        check("t5_flags", {29'd0, bus.flag_v, bus.flag_z, bus.flag_n}, 32'd0);

        // Both requesters continuously valid after reset
        gseq.delete();
        gcyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'd0, 16'(i), 16'h0100));
            q1.push_back(mk(4'd1, 16'(i), 16'h0003));
        end
        wait_idle(100);
        check("t2_count", {31'd0, gseq.size() >= 4}, 32'd1);
        if (gseq.size() >= 4) begin
`ifdef ALU_FIXED_PRIO_EN
            check("t2_order", {28'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b0000);
`else
            check("t2_order", {28'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b0101);
`endif
            check("t2_b2b", 32'(gcyc[3] - gcyc[0]), 32'd6);
        end

        // Consumer stalls in RESP with a second requester pending
        @(posedge clk);
        #1 bus.rsp_rdy = 1'b0;
        q0.push_back(mk(4'd4, 16'hA5A5, 16'h0FF0));
        q1.push_back(mk(4'd5, 16'h0003, 16'h0000));
        repeat (8) @(posedge clk);
        #1 bus.rsp_rdy = 1'b1;
        wait_idle(50);

        // Random traffic with random back-pressure
        for (int i = 0; i < 12; i++) begin
            op_t o;
            o.op = 4'($urandom_range(0, 6)); o.a = 16'($urandom); o.b = 16'($urandom); o.sh = 4'($urandom);
            q0.push_back(o);
            o.op = 4'($urandom_range(0, 6)); o.a = 16'($urandom); o.b = 16'($urandom); o.sh = 4'($urandom);
            q1.push_back(o);
        end
        for (int i = 0; i < 600 && !is_idle(); i++) begin
            @(posedge clk);
            #1 bus.rsp_rdy = ($urandom_range(0, 3) != 0);
        end
        bus.rsp_rdy = 1'b1;
        wait_idle(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
